bit_morph_filter: RTL and testbench

Parametrised binary morphology stage for the 1-bit image path. It applies a K×K square structuring element with a per-frame selectable operation: bypass, erosion, dilation or morphological gradient. It contains its own K-1 line buffers and window generator and needs no external matrix generator. It sits after binarisation and before connected-component or bounding-box detectors.

---
 rtl/bit_morph_filter.sv | 177 +++++++++++++++++
 tb/tb_bit_morph_filter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bit_morph_filter.sv
// Binary KxK morphology stage (bypass / erode / dilate / gradient) with internal
// line buffers; the output window is causal, so the image is shifted R lines down and R pixels right.
module bit_morph_filter #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter int          KSIZE     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_img_Bit,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_img_Bit
);

  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int RW = $clog2(IMG_VDISP + 1);
  localparam int AW = (IMG_HDISP > 11'd1) ? $clog2(IMG_HDISP) : 1;
  localparam logic [CW-1:0] HMAX = CW'(IMG_HDISP);
  localparam logic [RW-1:0] VMAX = RW'(IMG_VDISP);

  if (!(KSIZE == 3 || KSIZE == 5 || KSIZE == 7)) begin : g_bad_ksize
    $error("bit_morph_filter: KSIZE must be 3, 5 or 7");
  end

  function automatic logic [CW-1:0] sat_inc_col(input logic [CW-1:0] v);
    return (v < HMAX) ? v + 1'b1 : HMAX;
  endfunction

  function automatic logic [RW-1:0] sat_inc_row(input logic [RW-1:0] v);
    return (v < VMAX) ? v + 1'b1 : VMAX;
  endfunction

  // control state
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic          line_q, line_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic          vs_rise, hr_rise, hr_fall, line_cur, pix_ok;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;
  logic [AW-1:0] addr;

  // window storage: line buffers and per-row horizontal shifters
  logic [IMG_HDISP-1:0] lb_q [KSIZE-1];
  logic [KSIZE-1:1]     sh_q [KSIZE];
  logic [KSIZE-1:1]     sh_d [KSIZE];
  logic [KSIZE-1:0]     col_bit;
  logic [KSIZE-1:0]     win [KSIZE];
  logic                 win_vld;

  // pipeline registers
  logic [KSIZE-1:0] row_and_p1_q, row_and_p1_d;
  logic [KSIZE-1:0] row_or_p1_q, row_or_p1_d;
  logic             raw_p1_q, raw_p1_d;
  logic             ok_p1_q, ok_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic             vsync_p1_q, vsync_p1_d;
  logic             bit_p2_q, bit_p2_d;
  logic             vld_p2_q, vld_p2_d;
  logic             vsync_p2_q, vsync_p2_d;
  logic             erode, dilate, sel;

  always_comb begin
    vs_rise  = per_frame_vsync & ~vsync_q;
    hr_rise  = per_frame_href & ~href_q;
    hr_fall  = ~per_frame_href & href_q;
    col_cur  = hr_rise ? '0 : col_q;
    row_cur  = vs_rise ? '0 : row_q;
    line_cur = vs_rise ? 1'b0 : line_q;
    pix_ok   = per_frame_href & (col_cur < HMAX);
    addr     = pix_ok ? col_cur[AW-1:0] : '0;

    vsync_d = per_frame_vsync;
    href_d  = per_frame_href;
    mode_d  = vs_rise ? mode : mode_q;
    line_d  = line_cur | hr_rise;
    col_d   = per_frame_href ? sat_inc_col(col_cur) : col_q;
    row_d   = (hr_fall && line_cur) ? sat_inc_row(row_cur) : row_cur;
  end

  // stage 0 -> 1: build the padded window and reduce each row
  always_comb begin
    col_bit[0] = per_img_Bit;
    for (int i = 1; i < KSIZE; i++) col_bit[i] = lb_q[i-1][addr];
    for (int i = 0; i < KSIZE; i++) win[i] = {sh_q[i], col_bit[i]};

    sh_d = sh_q;
    if (pix_ok)
      for (int i = 0; i < KSIZE; i++) sh_d[i] = win[i][KSIZE-2:0];

    row_and_p1_d = '1;
    row_or_p1_d  = '0;
    win_vld      = 1'b0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        // taps above row 0 or left of col 0 take the neutral value
        win_vld = (row_cur >= RW'(i)) && (col_cur >= CW'(j));
        row_and_p1_d[i] = row_and_p1_d[i] & (win_vld ? win[i][j] : 1'b1);
        row_or_p1_d[i]  = row_or_p1_d[i] | (win_vld & win[i][j]);
      end
    end
    raw_p1_d   = per_img_Bit;
    ok_p1_d    = pix_ok;
    vld_p1_d   = per_frame_href;
    vsync_p1_d = per_frame_vsync;
  end

  // stage 1 -> 2: combine rows and select the operation
  always_comb begin
    erode  = &row_and_p1_q;
    dilate = |row_or_p1_q;
    unique case (mode_q)
      2'b00:   sel = raw_p1_q;
      2'b01:   sel = erode;
      2'b10:   sel = dilate;
      default: sel = erode ^ dilate;
    endcase
    bit_p2_d   = ok_p1_q & vld_p1_q & sel;
    vld_p2_d   = vld_p1_q;
    vsync_p2_d = vsync_p1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      line_q       <= 1'b0;
      mode_q       <= 2'b00;
      col_q        <= '0;
      row_q        <= '0;
      row_and_p1_q <= '0;
      row_or_p1_q  <= '0;
      raw_p1_q     <= 1'b0;
      ok_p1_q      <= 1'b0;
      vld_p1_q     <= 1'b0;
      vsync_p1_q   <= 1'b0;
      bit_p2_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vsync_p2_q   <= 1'b0;
    end else begin
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      line_q       <= line_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_and_p1_q <= row_and_p1_d;
      row_or_p1_q  <= row_or_p1_d;
      raw_p1_q     <= raw_p1_d;
      ok_p1_q      <= ok_p1_d;
      vld_p1_q     <= vld_p1_d;
      vsync_p1_q   <= vsync_p1_d;
      bit_p2_q     <= bit_p2_d;
      vld_p2_q     <= vld_p2_d;
      vsync_p2_q   <= vsync_p2_d;
    end
  end

  // line-buffer cascade: buffer n receives the row-n tap read this cycle
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
    if (pix_ok)
      for (int n = 0; n < KSIZE - 1; n++) lb_q[n][addr] <= col_bit[n];
  end

  assign post_frame_vsync = vsync_p2_q;
  assign post_frame_href  = vld_p2_q;
  assign post_img_Bit     = bit_p2_q;

endmodule

// File: tb/tb_bit_morph_filter.sv
// Scoreboard bench for bit_morph_filter: KSIZE=3 and KSIZE=5 instances on a 16x8
// frame share the stimulus; expected pixels are queued at issue time and popped on post_frame_href.
module tb_bit_morph_filter;
  localparam int H = 16;
  localparam int V = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, vs, hr, px;
  logic [1:0] mode;
  logic       pv3, ph3, pb3, pv5, ph5, pb5;

  bit img [0:V-1][0:H-1];
  bit q3[$], q5[$];
  int cq3[$], cq5[$];
  int checks = 0, errors = 0;
  bit chk_en = 1'b0, done = 1'b0;

  bit_morph_filter #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd8), .KSIZE(3)) u_k3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .per_frame_vsync(vs), .per_frame_href(hr),
    .per_img_Bit(px), .post_frame_vsync(pv3), .post_frame_href(ph3), .post_img_Bit(pb3));

  bit_morph_filter #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd8), .KSIZE(5)) u_k5 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .per_frame_vsync(vs), .per_frame_href(hr),
    .per_img_Bit(px), .post_frame_vsync(pv5), .post_frame_href(ph5), .post_img_Bit(pb5));

  // reference: out(r,c) combines in(r-i, c-j), i,j < k; taps outside the frame are neutral
  function automatic bit exp_pix(int k, logic [1:0] m, int r, int c);
    bit er = 1'b1;
    bit di = 1'b0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        if (r - i >= 0 && c - j >= 0) begin
          er = er & img[r-i][c-j];
          di = di | img[r-i][c-j];
        end
    case (m)
      2'b00:   return img[r][c];
      2'b01:   return er;
      2'b10:   return di;
      default: return er ^ di;
    endcase
  endfunction

  task automatic set_pattern(input int pat);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        case (pat)
          1:       img[r][c] = (r == 3 && c == 5);
          2:       img[r][c] = (r >= 2 && r <= 6 && c >= 4 && c <= 8);
          3:       img[r][c] = (r == 0 && c == 0);
          4:       img[r][c] = 1'b1;
          5:       img[r][c] = (r >= 2 && r <= 5 && c >= 5 && c <= 8);
          default: img[r][c] = 1'b0;
        endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      vs = 1'b0; hr = 1'b0; px = 1'b0;
    end
  endtask

  task automatic send_frame(input int pat, input logic [1:0] m0, input logic [1:0] m1,
                            input bit simul, input bit do_rst, input int e3, input int e5);
    set_pattern(pat);
    if (chk_en) begin
      cq3.push_back(e3);
      cq5.push_back(e5);
    end
    mode = m0;
    if (!simul)
      for (int n = 0; n < 5; n++) begin
        tick();
        vs = (n < 2); hr = 1'b0; px = 1'b0;
      end
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        tick();
        vs = simul && (r == 0);
        if (r == 3 && c == 0) mode = m1;
        hr = 1'b1;
        px = img[r][c];
        if (do_rst && r == 3 && c == 7) rst_n = 1'b0;
        if (chk_en) begin
          q3.push_back(exp_pix(3, m0, r, c));
          q5.push_back(exp_pix(5, m0, r, c));
        end
      end
      idle(4);
    end
    idle(4);
  endtask

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", name, got, exp, $time);
    end
  endfunction

  // monitor: the only process that steps checks/errors
  initial begin : monitor
    bit hh0 = 0, hh1 = 0, vh0 = 0, vh1 = 0, pv_prev = 0, in_frame = 0;
    int cnt3 = 0, cnt5 = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        chk("q3_drained", q3.size(), 0);
        chk("q5_drained", q5.size(), 0);
        chk("frames_closed", cq3.size() + cq5.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (!rst_n) begin
        chk("rst_vsync_k3", pv3, 0); chk("rst_href_k3", ph3, 0); chk("rst_bit_k3", pb3, 0);
        chk("rst_vsync_k5", pv5, 0); chk("rst_href_k5", ph5, 0); chk("rst_bit_k5", pb5, 0);
      end else begin
        if (pv3 && !pv_prev) begin
          if (in_frame) begin
            if (cq3.size() == 0 || cq5.size() == 0) chk("frame_count_missing", 1, 0);
            else begin
              chk("ones_per_frame_k3", cnt3, cq3.pop_front());
              chk("ones_per_frame_k5", cnt5, cq5.pop_front());
            end
          end
          in_frame = chk_en;
          cnt3 = 0;
          cnt5 = 0;
        end
        if (chk_en) begin
          chk("href_delay_k3", ph3, hh1); chk("vsync_delay_k3", pv3, vh1);
          chk("href_delay_k5", ph5, hh1); chk("vsync_delay_k5", pv5, vh1);
          if (ph3) begin
            if (q3.size() == 0) chk("k3_unexpected_pixel", 1, 0);
            else chk("pixel_k3", pb3, q3.pop_front());
          end else chk("blank_k3", pb3, 0);
          if (ph5) begin
            if (q5.size() == 0) chk("k5_unexpected_pixel", 1, 0);
            else chk("pixel_k5", pb5, q5.pop_front());
          end else chk("blank_k5", pb5, 0);
        end
        if (ph3 && pb3) cnt3++;
        if (ph5 && pb5) cnt5++;
      end
      pv_prev = pv3;
      hh1 = hh0; hh0 = hr;
      vh1 = vh0; vh0 = vs;
    end
  end

  initial begin : stimulus
    rst_n = 1'b0; vs = 1'b0; hr = 1'b0; px = 1'b0; mode = 2'b00;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    idle(3);
    chk_en = 1'b1;
    send_frame(1, 2'b01, 2'b01, 1'b0, 1'b0, 0, 0);      // erode, isolated pixel
    send_frame(2, 2'b01, 2'b01, 1'b0, 1'b0, 9, 1);      // erode, 5x5 block
    send_frame(4, 2'b00, 2'b00, 1'b0, 1'b0, 128, 128);  // all-ones frame leaves stale buffers
    send_frame(3, 2'b10, 2'b10, 1'b0, 1'b0, 9, 25);     // dilate single pixel at (0,0)
    send_frame(5, 2'b11, 2'b11, 1'b1, 1'b0, 32, 48);    // gradient, vsync+href rise together
    send_frame(2, 2'b01, 2'b10, 1'b0, 1'b0, 9, 1);      // mode flips mid-frame, erode holds
    send_frame(2, 2'b10, 2'b10, 1'b0, 1'b0, 42, 54);    // dilate from next vsync
    send_frame(2, 2'b00, 2'b00, 1'b0, 1'b0, 25, 25);    // bypass
    chk_en = 1'b0;
    send_frame(2, 2'b01, 2'b01, 1'b0, 1'b1, 0, 0);      // reset at row 3 col 7
    chk_en = 1'b1;
    send_frame(2, 2'b01, 2'b01, 1'b0, 1'b0, 9, 1);      // clean frame after reset
    chk_en = 1'b0;
    tick(); vs = 1'b1;
    tick(); vs = 1'b0;
    idle(5);
    done = 1'b1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
